// File: rtl/lsu_bus_ctrl.sv
// Load/store bus sequencer: one valid/ack bus transaction per memory instruction,
// with stall generation, load lane formatting, misalignment rejection and timeout abort.
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_mask,
  input  logic [2:0]  load_ctrl,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_p0;
  logic [31:0]      addr_p0;
  logic [31:0]      wdata_p0;
  logic [3:0]       be_p0;
  logic [2:0]       ctrl_p0;
  logic             start;

  function automatic logic misaligned_f(input logic [2:0] ctrl, input logic [1:0] a);
    case (ctrl)
      3'b000, 3'b011: return 1'b0;
      3'b001, 3'b100: return a[0];
      default:        return a != 2'b00;
    endcase
  endfunction

  // Sub-word stores take the caller's mask; word stores ignore it since it is undefined there.
  function automatic logic [3:0] be_f(input logic we, input logic [2:0] ctrl,
                                      input logic [3:0] mask);
    if (!we) return 4'b1111;
    case (ctrl)
      3'b000, 3'b001, 3'b011, 3'b100: return mask;
      default:                        return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] format_f(input logic [2:0] ctrl, input logic [1:0] a,
                                           input logic [31:0] rdata);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    b = rdata[7:0];
    case (a)
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h  = a[1] ? rdata[31:16] : rdata[15:0];
    sb = $signed(b);
    sh = $signed(h);
    case (ctrl)
      3'b000:  return 32'(sb);
      3'b001:  return 32'(sh);
      3'b011:  return {24'h0, b};
      3'b100:  return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  assign misalign  = (state == IDLE) && core_valid && misaligned_f(load_ctrl, core_addr[1:0]);
  assign start     = (state == IDLE) && core_valid && !misaligned_f(load_ctrl, core_addr[1:0]);
  assign stall     = start || (state == BUS);
  assign bus_we    = we_p0;
  assign bus_addr  = {addr_p0[31:2], 2'b00};
  assign bus_be    = be_p0;
  assign bus_wdata = wdata_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      we_p0     <= 1'b0;
      addr_p0   <= '0;
      wdata_p0  <= '0;
      be_p0     <= '0;
      ctrl_p0   <= '0;
      bus_req   <= 1'b0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      load_data <= '0;
    end else begin
      done    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            we_p0    <= core_we;
            addr_p0  <= core_addr;
            wdata_p0 <= core_wdata;
            be_p0    <= be_f(core_we, load_ctrl, core_mask);
            ctrl_p0  <= load_ctrl;
            cnt      <= '0;
            bus_req  <= 1'b1;
            state    <= BUS;
          end
        end
        // Ack wins over timeout when both land on the final wait cycle.
        BUS: begin
          if (bus_ack) begin
            load_data <= we_p0 ? 32'h0 : format_f(ctrl_p0, addr_p0[1:0], bus_rdata);
            done      <= 1'b1;
            bus_req   <= 1'b0;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            load_data <= 32'h0;
            bus_err   <= 1'b1;
            done      <= 1'b1;
            bus_req   <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: stimulus queues expected bus requests, completions
// and misalign pulses; an independent monitor pops and compares them as the DUT presents them.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_valid, core_we;
  logic [31:0] core_addr, core_wdata;
  logic [3:0]  core_mask;
  logic [2:0]  load_ctrl;
  logic        stall, done, misalign, bus_err, bus_req, bus_we, bus_ack;
  logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } done_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  done_t exp_done[$];
  req_t  exp_req[$];
  int    mis_expected = 0;

  lsu_bus_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .core_valid(core_valid), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_mask(core_mask),
    .load_ctrl(load_ctrl), .stall(stall), .load_data(load_data), .done(done),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, after stimulus has settled.
  initial begin
    logic  req_prev;
    done_t d;
    req_t  r;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (done === 1'b1) begin
        chk("done_expected", 32'(exp_done.size() > 0), 32'd1);
        if (exp_done.size() > 0) begin
          d = exp_done.pop_front();
          chk("load_data", load_data, d.data);
          chk("bus_err", 32'(bus_err), 32'(d.err));
          chk("stall_in_done", 32'(stall), 32'd0);
          chk("req_in_done", 32'(bus_req), 32'd0);
        end
      end
      if (misalign === 1'b1) begin
        chk("misalign_expected", 32'(mis_expected > 0), 32'd1);
        if (mis_expected > 0) mis_expected--;
        chk("misalign_stall", 32'(stall), 32'd0);
      end
      if (bus_req === 1'b1 && !req_prev) begin
        chk("req_expected", 32'(exp_req.size() > 0), 32'd1);
        if (exp_req.size() > 0) begin
          r = exp_req.pop_front();
          chk("bus_we", 32'(bus_we), 32'(r.we));
          chk("bus_addr", bus_addr, r.addr);
          chk("bus_be", 32'(bus_be), 32'(r.be));
          chk("bus_wdata", bus_wdata, r.wdata);
        end
      end
      req_prev = (bus_req === 1'b1);
    end
  end

  // lat = number of request cycles before ack; 0 means the bus never answers.
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic [2:0] ctrl, input int lat, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_req_cycles);
    int stall_cnt = 0;
    int req_cnt   = 0;
    int cyc       = 0;
    @(negedge clk);
    core_valid = 1'b1;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
    core_mask  = mask;
    load_ctrl  = ctrl;
    #1;
    while (done !== 1'b1 && cyc < 40) begin
      if (stall === 1'b1) stall_cnt++;
      if (bus_req === 1'b1) begin
        req_cnt++;
        if (req_cnt == lat) begin
          bus_ack   = 1'b1;
          bus_rdata = rdata;
        end
      end
      @(negedge clk);
      core_valid = 1'b0;
      bus_ack    = 1'b0;
      bus_rdata  = 32'h0;
      #1;
      cyc++;
    end
    if (cyc >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_no_done: got no done within 40 cycles, required done", name);
    end
    chk({name, "_req_cycles"}, 32'(req_cnt), 32'(exp_req_cycles));
    chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_req_cycles + 1));
  endtask

  task automatic push_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] data, input logic err);
    exp_req.push_back('{we: we, addr: addr, be: be, wdata: wdata});
    exp_done.push_back('{data: data, err: err});
  endtask

  task automatic run_misalign(input string name, input logic [31:0] addr, input logic [2:0] ctrl);
    mis_expected++;
    @(negedge clk);
    core_valid = 1'b1;
    core_we    = 1'b0;
    core_addr  = addr;
    load_ctrl  = ctrl;
    #1;
    chk({name, "_pulse"}, 32'(misalign), 32'd1);
    chk({name, "_stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    core_valid = 1'b0;
    #1;
    chk({name, "_no_req"}, 32'(bus_req), 32'd0);
    chk({name, "_pulse_end"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    core_valid = 1'b0;
    core_we    = 1'b0;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    core_mask  = 4'h0;
    load_ctrl  = 3'b010;
    bus_ack    = 1'b0;
    bus_rdata  = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    rst = 1'b0;

    push_txn(1'b0, 32'h1000, 4'b1111, 32'h0, 32'hFFFF_FF80, 1'b0);
    run_txn("lb", 1'b0, 32'h1003, 32'h0, 4'h0, 3'b000, 2, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0, 2);

    push_txn(1'b0, 32'h2000, 4'b1111, 32'h0, 32'h0000_BEEF, 1'b0);
    run_txn("lhu", 1'b0, 32'h2002, 32'h0, 4'h0, 3'b100, 1, 32'hBEEF_0000, 32'h0000_BEEF, 1'b0, 1);

    push_txn(1'b0, 32'h2000, 4'b1111, 32'h0, 32'hFFFF_BEEF, 1'b0);
    run_txn("lh", 1'b0, 32'h2002, 32'h0, 4'h0, 3'b001, 3, 32'hBEEF_0000, 32'hFFFF_BEEF, 1'b0, 3);

    push_txn(1'b1, 32'h10, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0);
    run_txn("sb", 1'b1, 32'h11, 32'h0000_AB00, 4'b0010, 3'b000, 1, 32'h0, 32'h0, 1'b0, 1);

    push_txn(1'b1, 32'h20, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
    run_txn("sw", 1'b1, 32'h20, 32'hDEAD_BEEF, 4'bxxxx, 3'b010, 2, 32'h0, 32'h0, 1'b0, 2);

    run_misalign("lw_mis", 32'h6, 3'b010);
    run_misalign("lh_mis", 32'h5, 3'b001);

    push_txn(1'b0, 32'h3000, 4'b1111, 32'h0, 32'h0000_00C3, 1'b0);
    run_txn("lbu", 1'b0, 32'h3001, 32'h0, 4'h0, 3'b011, 1, 32'h0000_C300, 32'h0000_00C3, 1'b0, 1);

    push_txn(1'b0, 32'h44, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
    run_txn("lw_code7", 1'b0, 32'h44, 32'h0, 4'h0, 3'b111, 2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2);
    @(negedge clk);
    #1;
    chk("load_data_hold", load_data, 32'hCAFE_F00D);
    chk("done_single_pulse", 32'(done), 32'd0);

    push_txn(1'b0, 32'h0, 4'b1111, 32'h0, 32'h0000_007F, 1'b0);
    run_txn("lb_pos", 1'b0, 32'h2, 32'h0, 4'h0, 3'b000, 1, 32'h007F_0000, 32'h0000_007F, 1'b0, 1);

    push_txn(1'b0, 32'h80, 4'b1111, 32'h0, 32'h0, 1'b1);
    run_txn("timeout", 1'b0, 32'h80, 32'h0, 4'h0, 3'b010, 0, 32'h0, 32'h0, 1'b1, 16);

    push_txn(1'b0, 32'h84, 4'b1111, 32'h0, 32'h5A5A_5A5A, 1'b0);
    run_txn("ack_last", 1'b0, 32'h84, 32'h0, 4'h0, 3'b010, 16, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 16);

    // Reset during BUS, then a stray ack that must not complete anything.
    exp_req.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1111, wdata: 32'h0});
    @(negedge clk);
    core_valid = 1'b1;
    core_we    = 1'b0;
    core_addr  = 32'h100;
    load_ctrl  = 3'b010;
    @(negedge clk);
    core_valid = 1'b0;
    #1;
    chk("rst_mid_req_before", 32'(bus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("late_ack_done", 32'(done), 32'd0);
    chk("late_ack_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    #1;
    chk("late_ack_done2", 32'(done), 32'd0);

    repeat (3) @(negedge clk);
    chk("pending_done", 32'(exp_done.size()), 32'd0);
    chk("pending_req", 32'(exp_req.size()), 32'd0);
    chk("pending_misalign", 32'(mis_expected), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Multi-cycle load/store sequencer between the store-formatting stage (byte mask and lane-aligned write data) and an external data-memory bus with variable latency.
- Takes each memory instruction and runs one bus transaction with a valid/ack handshake.
- Stalls the core until the transaction completes.
- Returns load data that has been lane-selected and sign- or zero-extended, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for bus_ack before aborting with bus_err.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- core_valid  in  1  current instruction is a load or store.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  32  byte address.
- core_wdata  in  32  lane-aligned store data.
- core_mask  in  4  store byte enables; undefined for word stores.
- load_ctrl  in  3  size code: 000 b, 001 h, 010 w, 011 bu, 100 hu; others treated as w.
- stall  out  1  hold PC and pipeline.
- load_data  out  32  extended load result; valid when done=1.
- done  out  1  one-cycle pulse, transaction finished.
- misalign  out  1  one-cycle pulse, access rejected.
- bus_err  out  1  one-cycle pulse with done, timeout occurred.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word-aligned address, {core_addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  write data.
- bus_ack  in  1  bus completion, single cycle.
- bus_rdata  in  32  read word; valid when bus_ack=1.

Behaviour:
- States are IDLE, BUS, DONE. Reset enters IDLE.
- Reset values: all registered outputs 0, timeout counter 0, captured request registers 0.
- Reset mid-transaction: return to IDLE; drop bus_req in the cycle following the reset edge; ignore any late bus_ack.
- Misalignment rules:
  - Halfword (001/100) with addr[0]=1 is misaligned.
  - Word (010/other) with addr[1:0]≠00 is misaligned.
  - Bytes are never misaligned.
- IDLE, core_valid=1 and aligned:
  - stall=1 combinationally.
  - Capture we, addr, wdata, be, load_ctrl.
  - Clear the counter and go to BUS.
- IDLE, core_valid=1 and misaligned:
  - misalign=1 combinationally, stall=0, no bus activity, stay in IDLE.
- Byte enables:
  - Store b/h: bus_be = core_mask.
  - Store word: bus_be forced to 1111.
  - Any load: bus_be = 1111.
- BUS:
  - bus_req=1 and stall=1; bus_addr, bus_we, bus_be and bus_wdata held stable from the captured values.
  - bus_ack=1: register formatted load data, go to DONE.
  - Otherwise increment the counter.
  - Counter reaching TIMEOUT-1 without ack: set the error flag, load_data = 0, go to DONE.
  - Request is issued in the cycle after entry, so minimum latency is one BUS cycle.
- DONE:
  - done=1, stall=0, bus_err = error flag, bus_req=0; go to IDLE.
  - The core advances exactly one instruction. The next core_valid is sampled in IDLE on the following cycle, so back-to-back memory instructions cost a minimum of 3 cycles each.
- Load formatting, using captured addr[1:0]:
  - Byte lane = rdata[8*a+7:8*a].
  - Halfword = rdata[31:16] if a[1] else rdata[15:0].
  - b/h sign-extend; bu/hu zero-extend; w passes through.
- Stores: load_data = 0 in DONE.
- load_data holds its last value outside DONE.
- bus_ack arriving in IDLE or DONE is ignored.

Test Plan:
- LB at addr 0x1003, bus returns 0x80FF_1234 after 2 cycles -> stall high 3 cycles, done pulse, load_data = 0xFFFF_FF80.
- LHU at addr 0x2002, rdata 0xBEEF_0000 -> load_data = 0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SB at addr 0x11, core_mask 0010, wdata 0x0000_AB00 -> bus_addr 0x10, bus_be 0010, bus_we 1, load_data 0.
- SW with core_mask = xxxx -> bus_be 1111; LW at addr 0x6 -> misalign pulse, no bus_req, stall 0.
- No bus_ack, TIMEOUT=16 -> bus_req high exactly 16 cycles, then done and bus_err together, load_data 0.
- rst asserted during BUS -> next cycle state IDLE, bus_req 0, stall 0; a late bus_ack produces no done.
